data_memory_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 32-bit single-cycle data memory. It shares one memory port between the processor load/store path (port A) and a debug/loader path (port B). It serializes their accesses through a three-state FSM with a req/done handshake. It sits between the requesters and the data memory unit, and it is the only agent that drives the memory's read and write strobes.

---
 rtl/data_memory_arbiter_if.sv | 35 +++
 rtl/data_memory_arbiter.sv | 134 +++++++++++++
 tb/tb_data_memory_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_if.sv
// Request/response bundle between the two requesters (A = load/store, B = debug/loader)
// and the data memory arbiter.
interface data_memory_arbiter_if;
   logic        a_req;
   logic        a_we;
   logic [31:0] a_addr;
   logic [31:0] a_wdata;
   logic        a_done;
   logic        a_err;
   logic [31:0] a_rdata;

   logic        b_req;
   logic        b_we;
   logic [31:0] b_addr;
   logic [31:0] b_wdata;
   logic        b_done;
   logic        b_err;
   logic [31:0] b_rdata;

   // Requester side.
   modport master (
      output a_req, a_we, a_addr, a_wdata,
      output b_req, b_we, b_addr, b_wdata,
      input  a_done, a_err, a_rdata,
      input  b_done, b_err, b_rdata
   );

   // Arbiter side.
   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      input  b_req, b_we, b_addr, b_wdata,
      output a_done, a_err, a_rdata,
      output b_done, b_err, b_rdata
   );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter/sequencer for the single-cycle data memory (IDLE -> ACCESS -> RESP).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority A > B.
module data_memory_arbiter #(
   parameter int unsigned MEM_WORDS = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   data_memory_arbiter_if.slave req_if,
   output logic [31:0]          mem_address,
   output logic [31:0]          mem_write_data,
   output logic                 mem_read,
   output logic                 mem_write,
   input  logic [31:0]          mem_read_data,
   output logic [1:0]           state_dbg
);

   // Handshake: a requester raises req with we/addr/wdata and holds it until its done
   // pulses for one cycle; it drops req the cycle after done. A req still high in IDLE
   // is a new request. The loser of arbitration simply keeps waiting, no acknowledge.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state;
   logic        lat_owner;   // 0 = port A, 1 = port B
   logic        lat_we;
   logic        lat_err;

   logic        req_any;
   logic        grant_b;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_oor;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic        last_grant;  // 1 = B was granted last, so A wins the next tie
`endif

   always_comb begin
      req_any = req_if.a_req | req_if.b_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (req_if.a_req && req_if.b_req) begin
         grant_b = ~last_grant;
      end else begin
         grant_b = req_if.b_req;
      end
`else
      grant_b = ~req_if.a_req;
`endif
      sel_we    = grant_b ? req_if.b_we    : req_if.a_we;
      sel_addr  = grant_b ? req_if.b_addr  : req_if.a_addr;
      sel_wdata = grant_b ? req_if.b_wdata : req_if.a_wdata;
      sel_oor   = (sel_addr >= MEM_WORDS);
   end

   assign state_dbg = state;

   // mem_address/mem_write_data double as the address/data latch for the access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         lat_owner      <= 1'b0;
         lat_we         <= 1'b0;
         lat_err        <= 1'b0;
         mem_address    <= '0;
         mem_write_data <= '0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         req_if.a_done  <= 1'b0;
         req_if.a_err   <= 1'b0;
         req_if.a_rdata <= '0;
         req_if.b_done  <= 1'b0;
         req_if.b_err   <= 1'b0;
         req_if.b_rdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_grant     <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_any) begin
                  lat_owner <= grant_b;
                  lat_we    <= sel_we;
                  lat_err   <= sel_oor;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  last_grant <= grant_b;
`endif
                  if (!sel_oor) begin
                     mem_address    <= sel_addr;
                     mem_write_data <= sel_wdata;
                     mem_read       <= ~sel_we;
                     mem_write      <= sel_we;
                  end
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               // An errored read returns zero; a write leaves rdata untouched.
               if (!lat_we) begin
                  if (lat_owner) begin
                     req_if.b_rdata <= lat_err ? 32'h0 : mem_read_data;
                  end else begin
                     req_if.a_rdata <= lat_err ? 32'h0 : mem_read_data;
                  end
               end
               if (lat_owner) begin
                  req_if.b_done <= 1'b1;
                  req_if.b_err  <= lat_err;
               end else begin
                  req_if.a_done <= 1'b1;
                  req_if.a_err  <= lat_err;
               end
               state <= RESP;
            end
            RESP: begin
               req_if.a_done <= 1'b0;
               req_if.a_err  <= 1'b0;
               req_if.b_done <= 1'b0;
               req_if.b_err  <= 1'b0;
               state         <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomized self-checking bench for data_memory_arbiter against a transaction-level
// model: memory array, per-port rdata, and an arbitration order computed per run.
module tb_data_memory_arbiter;

   localparam int WORDS = 256;

   logic        clk;
   logic        rst_n;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_read_data;
   logic [1:0]  state_dbg;

   data_memory_arbiter_if bus ();

   data_memory_arbiter #(.MEM_WORDS(WORDS)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_if         (bus),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_read_data  (mem_read_data),
      .state_dbg      (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- memory unit (environment) ----------------
   logic [31:0] mem_env [0:WORDS-1];
   logic        env_clear;

   assign mem_read_data = (mem_address < 32'd256) ? mem_env[mem_address[7:0]] : 32'h0;

   always @(posedge clk) begin
      if (env_clear) begin
         for (int i = 0; i < WORDS; i++) mem_env[i] <= 32'h0;
      end else if (mem_write && (mem_address < 32'd256)) begin
         mem_env[mem_address[7:0]] <= mem_write_data;
      end
   end

   // ---------------- reference model state ----------------
   logic [31:0] ref_mem [0:WORDS-1];
   logic [31:0] ref_rdata [2];
   bit          ref_last_b;

   // Per-port operation lists for one run.
   logic        op_we    [2][8];
   logic [31:0] op_addr  [2][8];
   logic [31:0] op_wdata [2][8];
   int          op_n     [2];

   logic [33:0] exp_q[$];      // {port, err, rdata} in expected done order
   logic [64:0] strobe_q[$];   // {we, addr, wdata} expected memory strobes

   int errors;
   int checks;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_port(input int p, input logic req, input logic we,
                             input logic [31:0] addr, input logic [31:0] wd);
      if (p == 0) begin
         bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
      end else begin
         bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
      end
   endtask

   task automatic set_op(input int p, input int i, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd);
      op_we[p][i]    = we;
      op_addr[p][i]  = addr;
      op_wdata[p][i] = wd;
   endtask

   // Serve pending ports one grant at a time; a port with operations left is always
   // requesting at the next arbitration point.
   task automatic predict();
      int  rem [2];
      int  idx [2];
      int  w;
      logic        we, oor;
      logic [31:0] addr, wd;
      rem[0] = op_n[0]; rem[1] = op_n[1];
      idx[0] = 0;       idx[1] = 0;
      while (rem[0] + rem[1] > 0) begin
         if (rem[0] > 0 && rem[1] > 0) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w = ref_last_b ? 0 : 1;
`else
            w = 0;
`endif
         end else begin
            w = (rem[0] > 0) ? 0 : 1;
         end
         ref_last_b = (w == 1);
         we   = op_we[w][idx[w]];
         addr = op_addr[w][idx[w]];
         wd   = op_wdata[w][idx[w]];
         oor  = (addr >= 32'(WORDS));
         if (!oor) begin
            strobe_q.push_back({we, addr, we ? wd : 32'h0});
            if (we) ref_mem[addr[7:0]] = wd;
            else    ref_rdata[w] = ref_mem[addr[7:0]];
         end else if (!we) begin
            ref_rdata[w] = 32'h0;
         end
         exp_q.push_back({(w == 1), oor, ref_rdata[w]});
         idx[w]++;
         rem[w]--;
      end
   endtask

   // Run one set of operations; with scramble, a lone single A op has its bus fields
   // changed right after grant.
   task automatic run_txn(input bit scramble);
      int          total, k, cnt, p;
      int          nxt [2];
      logic [33:0] e;
      logic [64:0] s;
      predict();
      total = op_n[0] + op_n[1];
      k = 0; cnt = 0;
      nxt[0] = 0; nxt[1] = 0;
      @(negedge clk);
      for (int q = 0; q < 2; q++) begin
         if (op_n[q] > 0) begin
            drive_port(q, 1'b1, op_we[q][0], op_addr[q][0], op_wdata[q][0]);
            nxt[q] = 1;
         end
      end
      while (k < total && cnt < 3 * total + 6) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
         if (scramble && cnt == 1 && op_n[0] == 1 && op_n[1] == 0) begin
            drive_port(0, 1'b1, ~bus.a_we, $urandom_range(0, 15), $urandom);
         end
         if (mem_read || mem_write) begin
            check_eq("strobe_excl", {63'h0, mem_read & mem_write}, 64'h0);
            if (strobe_q.size() == 0) begin
               check_eq("strobe_extra", 64'h1, 64'h0);
            end else begin
               s = strobe_q.pop_front();
               check_eq("strobe", {mem_write, mem_address, mem_write ? mem_write_data : 32'h0},
                        {s[64], s[63:32], s[31:0]});
            end
         end
         if (bus.a_done || bus.b_done) begin
            check_eq("done_excl", {63'h0, bus.a_done & bus.b_done}, 64'h0);
            p = bus.b_done ? 1 : 0;
            e = exp_q.pop_front();
            check_eq("done_port", 64'(p), {63'h0, e[33]});
            check_eq("done_err", {63'h0, (p == 1) ? bus.b_err : bus.a_err}, {63'h0, e[32]});
            check_eq("rdata", {32'h0, (p == 1) ? bus.b_rdata : bus.a_rdata}, {32'h0, e[31:0]});
            check_eq("done_latency", 64'(cnt), 64'(2 + 3 * k));
            k++;
            if (nxt[p] < op_n[p]) begin
               drive_port(p, 1'b1, op_we[p][nxt[p]], op_addr[p][nxt[p]], op_wdata[p][nxt[p]]);
               nxt[p]++;
            end else begin
               drive_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
            end
         end
      end
      if (k < total) check_eq("timeout", 64'(k), 64'(total));
      check_eq("strobe_missing", 64'(strobe_q.size()), 64'h0);
      exp_q.delete();
      strobe_q.delete();
      drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) begin
         @(negedge clk);
         check_eq("idle_quiet", {60'h0, bus.a_done, bus.b_done, mem_read, mem_write}, 64'h0);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return 32'd255;
         1:       return 32'd256;
         2:       return 32'd300;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom_range(0, 15);
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      errors = 0;
      checks = 0;
      for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
      ref_rdata[0] = 32'h0;
      ref_rdata[1] = 32'h0;
      ref_last_b   = 1'b1;
      op_n[0] = 0; op_n[1] = 0;
      drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
      rst_n     = 1'b0;
      env_clear = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      env_clear = 1'b0;
      check_eq("rst_strobes", {62'h0, mem_read, mem_write}, 64'h0);
      check_eq("rst_mem_bus", {mem_address, mem_write_data}, 64'h0);
      check_eq("rst_done_err", {60'h0, bus.a_done, bus.a_err, bus.b_done, bus.b_err}, 64'h0);
      check_eq("rst_rdata", {bus.a_rdata, bus.b_rdata}, 64'h0);
      rst_n = 1'b1;

      // A writes 5 = 31, then reads it back.
      op_n[0] = 1; op_n[1] = 0; set_op(0, 0, 1'b1, 32'd5, 32'd31);
      run_txn(1'b0);
      op_n[0] = 1; op_n[1] = 0; set_op(0, 0, 1'b0, 32'd5, 32'h0);
      run_txn(1'b0);

      // Simultaneous: A writes 10 = 8, B reads 10.
      op_n[0] = 1; op_n[1] = 1;
      set_op(0, 0, 1'b1, 32'd10, 32'd8);
      set_op(1, 0, 1'b0, 32'd10, 32'h0);
      run_txn(1'b0);

      // Both continuously requesting (alternation or starvation of B).
      op_n[0] = 2; op_n[1] = 2;
      for (int i = 0; i < 2; i++) begin
         set_op(0, i, 1'b1, 32'(20 + i), $urandom);
         set_op(1, i, 1'b0, 32'(20 + i), 32'h0);
      end
      run_txn(1'b0);
      op_n[0] = 4; op_n[1] = 1;
      for (int i = 0; i < 4; i++) set_op(0, i, 1'b1, 32'(30 + i), $urandom);
      set_op(1, 0, 1'b0, 32'd33, 32'h0);
      run_txn(1'b0);

      // Out-of-range and boundary addresses.
      op_n[0] = 1; op_n[1] = 1;
      set_op(0, 0, 1'b0, 32'd255, 32'h0);
      set_op(1, 0, 1'b0, 32'd300, 32'h0);
      run_txn(1'b0);
      op_n[0] = 0; op_n[1] = 1; set_op(1, 0, 1'b1, 32'd256, 32'hDEAD_BEEF);
      run_txn(1'b0);

      // Reset during ACCESS of A's write to addr 3.
      @(negedge clk);
      drive_port(0, 1'b1, 1'b1, 32'd3, 32'h5A5A_5A5A);
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_mid_pre", {63'h0, mem_write}, 64'h1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_strobe", {62'h0, mem_read, mem_write}, 64'h0);
      check_eq("rst_mid_bus", {mem_address, mem_write_data}, 64'h0);
      check_eq("rst_mid_rdata", {bus.a_rdata, bus.b_rdata}, 64'h0);
      drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      ref_rdata[0] = 32'h0;
      ref_rdata[1] = 32'h0;
      ref_last_b   = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check_eq("rst_no_done", {62'h0, bus.a_done, bus.b_done}, 64'h0);
      end
      op_n[0] = 1; op_n[1] = 0; set_op(0, 0, 1'b0, 32'd3, 32'h0);
      run_txn(1'b0);

      // A holds req through done: write then read of the same address.
      op_n[0] = 2; op_n[1] = 0;
      set_op(0, 0, 1'b1, 32'd7, 32'h1234_5678);
      set_op(0, 1, 1'b0, 32'd7, 32'h0);
      run_txn(1'b0);

      // Bus fields changed after grant have no effect.
      op_n[0] = 1; op_n[1] = 0; set_op(0, 0, 1'b1, 32'd12, 32'hCAFE_F00D);
      run_txn(1'b1);
      op_n[0] = 1; op_n[1] = 0; set_op(0, 0, 1'b0, 32'd12, 32'h0);
      run_txn(1'b0);

      // Randomized runs.
      for (int r = 0; r < 40; r++) begin
         op_n[0] = $urandom_range(0, 3);
         op_n[1] = $urandom_range(0, 3);
         if (op_n[0] + op_n[1] == 0) op_n[0] = 1;
         for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < op_n[p]; i++) begin
               set_op(p, i, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end
         end
         run_txn(1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
